// File: rtl/ahb2_cmd_master.sv
// ahb2_cmd_master: turns a valid/ready command stream into single NONSEQ
// AHB-Lite transfers. The address phase of the next command overlaps the
// data phase of the current one, so at most two commands are outstanding.
// Completions come back in order on a response port that cannot stall.
module ahb2_cmd_master #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_size,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [1:0]            htrans,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic [31:0]           hwdata,
  input  logic                  hready,
  input  logic                  hresp,
  input  logic [31:0]           hrdata
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Address-phase slot. haddr/hwrite/hsize double as its address, direction
  // and size storage: they are only reloaded when a new command is accepted.
  logic                  aph_valid;
  logic [31:0]           aph_wdata;
  // Data-phase slot.
  logic                  dph_valid;
  logic                  dph_write;
  // Set between the two cycles of an ERROR response; blocks new address phases.
  logic                  err_hold;

  logic                  accept;
  logic                  addr_done;
  logic                  dph_done;
  logic                  err_first;
  logic [1:0]            eff_size;
  logic [ADDR_WIDTH-1:0] aligned_addr;

  assign addr_done = (htrans == HTRANS_NONSEQ) && hready;
  assign dph_done  = dph_valid && hready;
  assign err_first = dph_valid && !hready && hresp;
  assign cmd_ready = !err_hold && (!aph_valid || addr_done);
  assign accept    = cmd_valid && cmd_ready;

  assign hburst = 3'b000;
  assign hprot  = HPROT_VAL;

  // Size 3 is illegal and issued as a word; drop the address bits below the size.
  always_comb begin
    // NOTE: every variable gets a default before the branches, so no path can
    // leave it unassigned and infer a latch.
    eff_size     = cmd_size;
    aligned_addr = cmd_addr;
    if (cmd_size == 2'd3) eff_size = 2'd2;
    case (eff_size)
      2'd1:    aligned_addr[0]   = 1'b0;
      2'd2:    aligned_addr[1:0] = 2'b00;
      default: ;
    endcase
  end

  // Address-phase slot and the registered address-phase bus signals.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      aph_valid <= 1'b0;
      aph_wdata <= '0;
      htrans    <= HTRANS_IDLE;
      haddr     <= '0;
      hwrite    <= 1'b0;
      hsize     <= 3'b000;
    end else begin
      if (accept) begin
        aph_valid <= 1'b1;
        aph_wdata <= cmd_wdata;
        haddr     <= aligned_addr;
        hwrite    <= cmd_write;
        hsize     <= {1'b0, eff_size};
      end else if (addr_done) begin
        aph_valid <= 1'b0;
      end

      // An ERROR forces IDLE for its second cycle; the held entry is re-driven
      // as a fresh NONSEQ once the ERROR completes.
      if (err_first)
        htrans <= HTRANS_IDLE;
      else if (accept)
        htrans <= HTRANS_NONSEQ;
      else if (addr_done)
        htrans <= HTRANS_IDLE;
      else if (err_hold && dph_done && aph_valid)
        htrans <= HTRANS_NONSEQ;
    end
  end

  // Data-phase slot; write data moves onto hwdata as the address phase completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dph_valid <= 1'b0;
      dph_write <= 1'b0;
      hwdata    <= '0;
    end else if (addr_done) begin
      dph_valid <= 1'b1;
      dph_write <= hwrite;
      if (hwrite) hwdata <= aph_wdata;
    end else if (dph_done) begin
      dph_valid <= 1'b0;
    end
  end

  // Track the two-cycle ERROR response.
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_hold <= 1'b0;
    else if (dph_done)
      err_hold <= 1'b0;
    else if (err_first)
      err_hold <= 1'b1;
  end

  // One-cycle completion pulse per finished data phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (dph_done) begin
      rsp_valid <= 1'b1;
      rsp_write <= dph_write;
      rsp_rdata <= dph_write ? 32'h0 : hrdata;
      rsp_err   <= hresp;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

  a_legal_size: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> (cmd_size != 2'd3));

endmodule

// File: tb/tb_ahb2_cmd_master.sv
// Directed bench for ahb2_cmd_master with a memory-style AHB slave model
// (programmable wait states and ERROR responses) and an in-order scoreboard.
module tb_ahb2_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready, hresp;
  logic [31:0] hrdata;

  ahb2_cmd_master #(.ADDR_WIDTH(32), .HPROT_VAL(4'b0011)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] wait_addr = 32'hFFFF_FFFF;
  int          wait_n    = 0;
  logic [31:0] err_addr  = 32'hFFFF_FFFF;

  logic [31:0] mem [0:1023];
  logic        s_dp_valid, s_dp_write;
  logic [31:0] s_dp_addr;
  int          s_wait;
  logic [1:0]  s_err;   // 0 none, 1 first ERROR cycle, 2 second ERROR cycle

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'h0;
    if (s_dp_valid) begin
      if (s_wait > 0) hready = 1'b0;
      else if (s_err == 2'd1) begin hready = 1'b0; hresp = 1'b1; end
      else if (s_err == 2'd2) begin hready = 1'b1; hresp = 1'b1; end
      hrdata = s_dp_write ? 32'hA5A5_A5A5 : mem[s_dp_addr[11:2]];
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      s_dp_valid <= 1'b0;
      s_dp_write <= 1'b0;
      s_dp_addr  <= '0;
      s_wait     <= 0;
      s_err      <= 2'd0;
      for (int i = 0; i < 1024; i++) mem[i] <= 32'(i * 4);
    end else if (!hready) begin
      if (s_wait > 0) s_wait <= s_wait - 1;
      else if (s_err == 2'd1) s_err <= 2'd2;
    end else begin
      if (s_dp_valid && s_dp_write && s_err == 2'd0) mem[s_dp_addr[11:2]] <= hwdata;
      s_dp_valid <= (htrans == 2'b10);
      s_dp_addr  <= haddr;
      s_dp_write <= hwrite;
      s_wait     <= (htrans == 2'b10 && haddr == wait_addr) ? wait_n : 0;
      s_err      <= (htrans == 2'b10 && haddr == err_addr) ? 2'd1 : 2'd0;
    end
  end

  // ---------------- response monitor ----------------
  int   rsp_count = 0;
  int   run       = 0;
  int   last_run  = 0;
  exp_t got;

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_count++;
      run++;
      check("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        got = sb_q.pop_front();
        check("rsp_write", rsp_write, got.write);
        check("rsp_rdata", rsp_rdata, got.rdata);
        check("rsp_err",   rsp_err,   got.err);
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = sz;
    cmd_wdata = wd;
    #1;
    for (int i = 0; i < 100 && !cmd_ready; i++) begin
      @(negedge clk);
      #1;
    end
    check("cmd_ready_accept", cmd_ready, 1'b1);
    e.write = wr;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    check("drain", sb_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int snap;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_htrans",    htrans,    2'b00);
    check("rst_haddr",     haddr,     32'h0);
    check("rst_hwrite",    hwrite,    1'b0);
    check("rst_hsize",     hsize,     3'b000);
    check("rst_hwdata",    hwdata,    32'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   rsp_err,   1'b0);
    check("rst_hburst",    hburst,    3'b000);
    check("rst_hprot",     hprot,     4'b0011);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1'b1);

    // Single zero-wait word write
    send(1'b1, 32'h100, 2'd2, 32'hDEAD_BEEF, 32'h0, 1'b0);
    idle();
    check("wr_htrans", htrans, 2'b10);
    check("wr_haddr",  haddr,  32'h100);
    check("wr_hwrite", hwrite, 1'b1);
    check("wr_hsize",  hsize,  3'b010);
    @(negedge clk);
    check("wr_hwdata",     hwdata, 32'hDEAD_BEEF);
    check("wr_htrans_idle", htrans, 2'b00);
    @(negedge clk);
    check("wr_rsp_valid", rsp_valid, 1'b1);
    check("wr_rsp_write", rsp_write, 1'b1);
    drain();

    // Four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 32'(i * 4), 2'd2, 32'h0, 32'(i * 4), 1'b0);
      check("b2b_htrans", htrans, 2'b10);
      check("b2b_haddr",  haddr,  32'(i * 4));
    end
    idle();
    drain();
    check("b2b_rsp_run", last_run, 4);

    // Two wait states on read 0x4 while read 0x8 sits in the address phase
    wait_addr = 32'h4;
    wait_n    = 2;
    send(1'b0, 32'h4, 2'd2, 32'h0, 32'h4, 1'b0);
    send(1'b0, 32'h8, 2'd2, 32'h0, 32'h8, 1'b0);
    idle();
    for (int i = 0; i < 2; i++) begin
      check("ws_htrans",    htrans,    2'b10);
      check("ws_haddr",     haddr,     32'h8);
      check("ws_cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
    end
    check("ws_htrans_last", htrans,    2'b10);
    check("ws_haddr_last",  haddr,     32'h8);
    check("ws_ready_again", cmd_ready, 1'b1);
    wait_addr = 32'hFFFF_FFFF;
    send(1'b0, 32'hC, 2'd2, 32'h0, 32'hC, 1'b0);
    idle();
    drain();

    // ERROR on write 0x200 with read 0x204 held in the address phase
    err_addr = 32'h200;
    send(1'b1, 32'h200, 2'd2, 32'h1234_5678, 32'h0, 1'b1);
    send(1'b0, 32'h204, 2'd2, 32'h0, 32'h204, 1'b0);
    idle();
    check("err_aph_haddr", haddr, 32'h204);
    @(negedge clk);
    check("err_htrans_idle", htrans,    2'b00);
    check("err_cmd_ready",   cmd_ready, 1'b0);
    err_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    check("err_redrive_htrans", htrans,    2'b10);
    check("err_redrive_haddr",  haddr,     32'h204);
    check("err_rsp_valid",      rsp_valid, 1'b1);
    check("err_rsp_err",        rsp_err,   1'b1);
    drain();

    // Alignment: halfword at 0x103, byte at 0xA3
    send(1'b1, 32'h103, 2'd1, 32'hBEEF_0000, 32'h0, 1'b0);
    idle();
    check("half_haddr", haddr, 32'h102);
    check("half_hsize", hsize, 3'b001);
    drain();
    send(1'b0, 32'hA3, 2'd0, 32'h0, 32'hA0, 1'b0);
    idle();
    check("byte_haddr", haddr, 32'hA3);
    check("byte_hsize", hsize, 3'b000);
    drain();

    // Synchronous reset with two commands outstanding
    wait_addr = 32'h10;
    wait_n    = 5;
    send(1'b0, 32'h10, 2'd2, 32'h0, 32'h10, 1'b0);
    send(1'b0, 32'h14, 2'd2, 32'h0, 32'h14, 1'b0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    snap = rsp_count;
    wait_addr = 32'hFFFF_FFFF;
    check("mrst_htrans",    htrans,    2'b00);
    check("mrst_haddr",     haddr,     32'h0);
    check("mrst_rsp_valid", rsp_valid, 1'b0);
    check("mrst_cmd_ready", cmd_ready, 1'b1);
    repeat (8) @(negedge clk);
    check("mrst_no_rsp", rsp_count, snap);
    send(1'b0, 32'h8, 2'd2, 32'h0, 32'h8, 1'b0);
    idle();
    check("mrst_new_htrans", htrans, 2'b10);
    check("mrst_new_haddr",  haddr,  32'h8);
    drain();
    check("mrst_one_rsp", rsp_count, snap + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb2_cmd_master.md
Name: ahb2_cmd_master

Overview:
- AHB2 (AHB-Lite) initiator for the simulation/SoC fabric. It converts a simple valid/ready command stream into single NONSEQ transfers.
- Transfers are pipelined: the address phase of command N+1 overlaps the data phase of command N.
- Completions return in order on a non-stallable response port.
- Drives memory-style slaves such as the team's AHB2 SRAM models, directly or through a decoder/mux.

Parameters:
- ADDR_WIDTH, 32, width of haddr and cmd_addr.
- HPROT_VAL, 4'b0011, constant hprot value (data, privileged).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at posedge
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_WIDTH  byte address
- cmd_size  input  2  0=byte, 1=half, 2=word; 3 is illegal
- cmd_wdata  input  32  write data, already lane-placed by the caller
- rsp_valid  output  1  one-cycle completion pulse
- rsp_write  output  1  echo of the completed command's write flag
- rsp_rdata  output  32  read data (0 for writes)
- rsp_err  output  1  slave returned ERROR
- htrans  output  2  IDLE=2'b00 or NONSEQ=2'b10 only
- haddr  output  ADDR_WIDTH  address-phase address
- hwrite  output  1  address-phase direction
- hsize  output  3  {1'b0, size}
- hburst  output  3  constant SINGLE (3'b000)
- hprot  output  4  constant HPROT_VAL
- hwdata  output  32  data-phase write data
- hready  input  1  bus ready (muxed hreadyout)
- hresp  input  1  0=OKAY, 1=ERROR
- hrdata  input  32  read data

Behaviour:
- Internal slots:
  - APH holds the command in its address phase: valid, write, addr, size, wdata.
  - DPH holds the command in its data phase: valid, write.
  - At most 2 commands are outstanding.
- All bus outputs are registered.
- Reset values: htrans=IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, APH/DPH empty.
- Address alignment: low bits are forced to zero. size 1 clears haddr[0]; size 2 clears haddr[1:0].
- Address phase completes at a posedge with htrans=NONSEQ & hready=1. At that edge:
  - APH moves to DPH.
  - hwdata <= APH.wdata for writes. For reads, hwdata holds its previous value.
- cmd_ready (combinational) = !err_hold & (!APH.valid | (htrans==NONSEQ & hready)).
- On acceptance, APH loads the new command, and htrans/haddr/hwrite/hsize are driven from it starting in the next cycle. If nothing is accepted and APH empties, htrans=IDLE.
- Latency: a command accepted at edge E appears on the bus in cycle E+1. With zero wait states, its data phase is E+2 and rsp_valid is high in E+3.
- Data phase completes at a posedge with DPH.valid & hready=1. At that edge:
  - rsp_valid <= 1.
  - rsp_write <= DPH.write.
  - rsp_rdata <= write ? 0 : hrdata.
  - rsp_err <= hresp.
  - rsp_valid deasserts in the next cycle unless another completion occurs. The response has no backpressure.
- Wait states (hready=0, hresp=0): all bus outputs are held stable and cmd_ready=0 when APH is occupied.
- ERROR, first cycle (DPH.valid & hready=0 & hresp=1):
  - At that edge, set err_hold.
  - If APH is valid, drive htrans=IDLE next cycle while keeping the APH entry (haddr etc. may stay).
- ERROR, second cycle (hready=1 & hresp=1):
  - The data phase completes with rsp_err=1.
  - err_hold clears. A held APH entry is re-driven as NONSEQ in the following cycle, which counts as a fresh address phase.
  - No command is dropped or reordered.
- rsp_err is set for any completion with hresp=1.
- Sync reset mid-operation: all slots are cleared, no response is produced for outstanding commands, and outputs return to reset values at the next edge.
- cmd_size=3 is illegal: a simulation assertion fires on acceptance, and the block issues the command as a word transfer.

Test Plan:
- Write 0xDEADBEEF to 0x100, size 2, zero-wait -> htrans=NONSEQ, haddr=0x100, hwrite=1 in cycle E+1; hwdata=0xDEADBEEF in E+2; rsp_valid, rsp_write=1, rsp_err=0 in E+3.
- Four back-to-back reads 0x0, 0x4, 0x8, 0xC on memory preloaded with data = address -> htrans=NONSEQ for 4 consecutive cycles; 4 consecutive rsp_valid with rsp_rdata 0x0, 0x4, 0x8, 0xC in order.
- Slave inserts 2 wait states on the read of 0x4 while the read of 0x8 is pending -> haddr=0x8/htrans stable for 3 cycles; cmd_ready=0 meanwhile; rsp order and data correct.
- ERROR on the write to 0x200 with read 0x204 in APH -> htrans=IDLE during the second ERROR cycle; rsp_err=1 for 0x200; read 0x204 re-issued as NONSEQ the next cycle and completes with rsp_err=0.
- Halfword write to address 0x103 -> haddr=0x102, hsize=3'b001.
- rst_n low for one cycle with 2 commands outstanding -> htrans=IDLE, no rsp_valid for either command; a new command afterwards completes normally.
